conv1d_window_buffer: RTL and testbench

//   Turns a serial stream of signed ECG samples into KERNEL-tap sliding windows for the 1-D conv MAC array.

---
 rtl/conv1d_window_buffer.sv | 158 +++++++++++++++
 tb/tb_conv1d_window_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_window_buffer.sv
// conv1d_window_buffer
//   Converts a serial stream of signed samples into KERNEL-tap sliding windows
//   for the 1-D convolution MAC array. It supports a configurable stride,
//   valid/ready handshakes on both sides, and segment framing via in_last_i.
//
//   Build option: CONV1D_ZERO_PAD_EN
//     When defined, each segment starts with (KERNEL-1)/2 zero taps ("same"
//     padding, leading side only).
//     When undefined, no padding is applied ("valid" convolution).
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous reset, active-low
//   in_valid_i   upstream sample valid
//   in_ready_o   block can accept a sample this cycle
//   in_data_i    signed sample, WIDTH bits
//   in_last_i    last sample of a segment (qualified by in_valid_i)
//   win_valid_o  window output valid
//   win_ready_i  downstream accepts the window
//   win_data_o   window; [WIDTH-1:0] is the oldest sample, the top slice is the newest
//   win_last_o   window was completed by the in_last_i sample
//
// state  | meaning
// S_FILL   | fewer than KERNEL taps valid in the current segment; no window is emitted
// S_STREAM | taps are full; a window is emitted on each accept where stride_q == 0
module conv1d_window_buffer #(
  parameter int WIDTH  = 8,
  parameter int KERNEL = 5,
  parameter int STRIDE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     in_last_i,
  output logic                     win_valid_o,
  input  logic                     win_ready_i,
  output logic [KERNEL*WIDTH-1:0]  win_data_o,
  output logic                     win_last_o
);

`ifdef CONV1D_ZERO_PAD_EN
  localparam int PAD = (KERNEL - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int KW = KERNEL * WIDTH;
  localparam int CW = $clog2(KERNEL + 1);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CW-1:0] FILL_START = CW'(PAD);
  localparam logic [CW-1:0] FILL_FULL  = CW'(KERNEL);
  localparam logic [SW-1:0] STRIDE_MAX = SW'(STRIDE - 1);

  typedef enum logic {S_FILL, S_STREAM} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   taps_q, taps_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [SW-1:0]   stride_q, stride_d;
  logic            win_valid_q, win_valid_d;
  logic [KW-1:0]   win_data_q, win_data_d;
  logic            win_last_q, win_last_d;

  logic            accept;
  logic            emit;
  logic            full_post;
  logic [CW-1:0]   fill_inc;
  logic [KW-1:0]   taps_shift;

  // Single output register: a sample may enter whenever the output slot is
  // empty or is being drained in the same cycle.
  assign in_ready_o = rst_ni & (~win_valid_q | win_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  // Newest sample enters at the top; the oldest drops off the bottom.
  assign taps_shift = {in_data_i, taps_q[KW-1:WIDTH]};
  assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + CW'(1);
  assign full_post  = (fill_inc == FILL_FULL);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_FILL;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_last_i)      state_d = S_FILL;
      else if (full_post) state_d = S_STREAM;
    end
  end

  // Output decode: the completing sample in S_FILL already has full post-shift taps.
  always_comb begin
    emit = 1'b0;
    if (accept && ((state_q == S_STREAM) || full_post) && (stride_q == '0))
      emit = 1'b1;
  end

  // Tap, fill and stride datapath. A last sample restores the start-of-segment
  // values so that the next segment never sees this segment's taps.
  always_comb begin
    taps_d   = taps_q;
    fill_d   = fill_q;
    stride_d = stride_q;
    if (accept) begin
      if (in_last_i) begin
        taps_d   = '0;
        fill_d   = FILL_START;
        stride_d = '0;
      end else begin
        taps_d = taps_shift;
        fill_d = fill_inc;
        if (full_post)
          stride_d = (stride_q == STRIDE_MAX) ? '0 : stride_q + SW'(1);
      end
    end
  end

  always_comb begin
    win_data_d  = win_data_q;
    win_last_d  = win_last_q;
    win_valid_d = win_valid_q;
    if (emit) begin
      win_data_d  = taps_shift;
      win_last_d  = in_last_i;
      win_valid_d = 1'b1;
    end else if (win_ready_i) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taps_q      <= '0;
      fill_q      <= FILL_START;
      stride_q    <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_last_q  <= 1'b0;
    end else begin
      taps_q      <= taps_d;
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_valid_o = win_valid_q;
  assign win_data_o  = win_data_q;
  assign win_last_o  = win_last_q;

endmodule

// File: tb/tb_conv1d_window_buffer.sv
module tb_conv1d_window_buffer;

  localparam int W = 8;
  localparam int K = 3;
`ifdef CONV1D_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  logic clk;
  logic rst_n;
  logic [1:0] in_valid, in_ready, in_last, win_valid, win_ready, win_last;
  logic [W-1:0]   in_data  [2];
  logic [K*W-1:0] win_data [2];

  int vectors;
  int miscompares;

  // Per-instance model: samples of the current segment and expected {last, window}.
  logic [W-1:0]   seg0 [$];
  logic [W-1:0]   seg1 [$];
  logic [K*W:0]   exp0 [$];
  logic [K*W:0]   exp1 [$];

  conv1d_window_buffer #(.WIDTH(W), .KERNEL(K), .STRIDE(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .in_last_i(in_last[0]), .win_valid_o(win_valid[0]), .win_ready_i(win_ready[0]),
    .win_data_o(win_data[0]), .win_last_o(win_last[0])
  );

  conv1d_window_buffer #(.WIDTH(W), .KERNEL(K), .STRIDE(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .in_last_i(in_last[1]), .win_valid_o(win_valid[1]), .win_ready_i(win_ready[1]),
    .win_data_o(win_data[1]), .win_last_o(win_last[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [K*W-1:0] pack3(input int a, input int b, input int c);
    logic [K*W-1:0] w;
    w = {c[W-1:0], b[W-1:0], a[W-1:0]};
    return w;
  endfunction

  task automatic model_clear();
    seg0.delete(); seg1.delete();
    exp0.delete(); exp1.delete();
    for (int i = 0; i < PAD; i++) begin
      seg0.push_back('0);
      seg1.push_back('0);
    end
  endtask

  // Window j of a segment covers samples j..j+K-1; only j multiple of stride emits.
  task automatic model_accept(input int sel, input int d, input bit l);
    logic [W-1:0]   s [$];
    logic [K*W-1:0] w;
    int n;
    int stride;
    stride = (sel == 0) ? 1 : 2;
    if (sel == 0) s = seg0; else s = seg1;
    s.push_back(d[W-1:0]);
    n = s.size();
    if (n >= K && ((n - K) % stride) == 0) begin
      w = '0;
      for (int i = 0; i < K; i++) w[i*W +: W] = s[n-K+i];
      if (sel == 0) exp0.push_back({l, w}); else exp1.push_back({l, w});
    end
    if (l) begin
      s.delete();
      for (int i = 0; i < PAD; i++) s.push_back('0);
    end
    if (sel == 0) seg0 = s; else seg1 = s;
  endtask

  // Scoreboard: compare each handshaken window against the model queue.
  always begin
    @(negedge clk);
    #2;
    for (int s = 0; s < 2; s++) begin
      if (win_valid[s] && win_ready[s]) begin
        logic [K*W:0] got, want;
        got = {win_last[s], win_data[s]};
        vectors++;
        if ((s == 0 && exp0.size() == 0) || (s == 1 && exp1.size() == 0)) begin
          miscompares++;
          $display("FAIL unexpected_window dut%0d got=%h required=none", s, got);
        end else begin
          if (s == 0) want = exp0.pop_front(); else want = exp1.pop_front();
          if (got !== want) begin
            miscompares++;
            $display("FAIL window dut%0d got=%h required=%h", s, got, want);
          end
        end
      end
    end
  end

  task automatic send(input int sel, input int d, input bit l);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid[sel] = 1'b1;
    in_data[sel]  = d[W-1:0];
    in_last[sel]  = l;
    #1;
    while (!in_ready[sel] && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready[sel]) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout dut%0d got=in_ready 0 required=1", sel);
      in_valid[sel] = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(sel, d, l);
    #1;
    in_valid[sel] = 1'b0;
    in_last[sel]  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = '0;
    in_last  = '0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain_check(input int sel);
    int left;
    repeat (4) @(negedge clk);
    #3;
    left = (sel == 0) ? exp0.size() : exp1.size();
    vectors++;
    if (left !== 0) begin
      miscompares++;
      $display("FAIL drain dut%0d got=%0d windows missing required=0", sel, left);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors += 5;
    if (win_valid !== 2'b00) begin miscompares++; $display("FAIL reset_win_valid got=%b required=00", win_valid); end
    if (in_ready !== 2'b00)  begin miscompares++; $display("FAIL reset_in_ready got=%b required=00", in_ready); end
    if (win_last !== 2'b00)  begin miscompares++; $display("FAIL reset_win_last got=%b required=00", win_last); end
    if (win_data[0] !== '0)  begin miscompares++; $display("FAIL reset_win_data0 got=%h required=0", win_data[0]); end
    if (win_data[1] !== '0)  begin miscompares++; $display("FAIL reset_win_data1 got=%h required=0", win_data[1]); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      send(0, i, 1'b0);
      if (i == 2 || i == 3) begin
        vectors++;
        if (win_valid[0] !== (exp0.size() != 0)) begin
          miscompares++;
          $display("FAIL latency_after_sample%0d got=%b required=%b", i, win_valid[0], exp0.size() != 0);
        end
      end
    end
    drain_check(0);
  endtask

  task automatic test_stride();
    apply_reset();
    for (int i = 1; i <= 7; i++) send(1, i, 1'b0);
    drain_check(1);
  endtask

  task automatic test_backpressure();
    logic [K*W-1:0] held;
    apply_reset();
    for (int i = 1; i <= 4; i++) send(0, i, 1'b0);
    @(negedge clk);
    win_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'd5;
    held = exp0[0][K*W-1:0];
    repeat (4) begin
      #1;
      vectors += 3;
      if (in_ready[0] !== 1'b0)  begin miscompares++; $display("FAIL bp_in_ready got=%b required=0", in_ready[0]); end
      if (win_valid[0] !== 1'b1) begin miscompares++; $display("FAIL bp_win_valid got=%b required=1", win_valid[0]); end
      if (win_data[0] !== held)  begin miscompares++; $display("FAIL bp_hold got=%h required=%h", win_data[0], held); end
      @(negedge clk);
    end
    in_valid[0]  = 1'b0;
    win_ready[0] = 1'b1;
    send(0, 5, 1'b0);
    drain_check(0);
  endtask

  task automatic test_framing();
    int seq_a [6] = '{-1, -2, -3, 10, 20, 30};
    int seq_b [5] = '{1, 2, 3, 4, 5};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send(0, seq_a[i], i == 2);
      if (i == 2) begin
        vectors++;
        if (win_last[0] !== 1'b1) begin miscompares++; $display("FAIL frame_win_last got=%b required=1", win_last[0]); end
      end
    end
    drain_check(0);
    apply_reset();
    for (int i = 0; i < 5; i++) send(0, seq_b[i], i == 1);
    drain_check(0);
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 1; i <= 3; i++) send(0, i, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors += 2;
    if (win_valid[0] !== 1'b0) begin miscompares++; $display("FAIL mid_reset_win_valid got=%b required=0", win_valid[0]); end
    if (in_ready[0] !== 1'b0)  begin miscompares++; $display("FAIL mid_reset_in_ready got=%b required=0", in_ready[0]); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 3; i <= 5; i++) send(0, i, 1'b0);
    drain_check(0);
  endtask

  task automatic test_back_to_back_segments();
    apply_reset();
    send(0, 7, 1'b0);
    send(0, 8, 1'b0);
    send(0, 9, 1'b1);
    send(0, 100, 1'b0);
    send(0, 101, 1'b0);
    send(0, 102, 1'b0);
    send(0, 103, 1'b0);
    drain_check(0);
    vectors++;
    if (pack3(101, 102, 103) !== win_data[0]) begin
      miscompares++;
      $display("FAIL last_window got=%h required=%h", win_data[0], pack3(101, 102, 103));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in_valid = '0;
    in_last  = '0;
    win_ready = 2'b11;
    in_data[0] = '0;
    in_data[1] = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_stream();
    test_stride();
    test_backpressure();
    test_framing();
    test_reset_midstream();
    test_back_to_back_segments();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
